// File: rtl/spi_msg_master.sv
// Master-side SPI register-protocol engine: frames one status/read/write request
// into command + payload bytes under slave select and returns the slave's answer.
module spi_msg_master #(
   parameter int SS_SETUP = 2,    // cycles from ssN low to first byteStart, >= 1
   parameter int BYTE_GAP = 1,    // idle cycles between bytes, 0 allowed
   parameter int TIMEOUT  = 1023  // cycles from byteStart to abort, >= 2
) (
   input  logic        sysClk,
   input  logic        usrReset,
   input  logic        reqValid,
   output logic        reqReady,
   input  logic [1:0]  reqOp,
   input  logic [3:0]  reqRegId,
   input  logic [31:0] reqWrData,
   output logic        rspValid,
   output logic [31:0] rspData,
   output logic        rspErr,
   output logic        ssN,
   output logic        byteStart,
   output logic [7:0]  byteTx,
   input  logic        byteBusy,
   input  logic        byteRxValid,
   input  logic [7:0]  byteRx
);

   // Handshake: a request transfers on a rising edge where reqValid & reqReady;
   // reqReady is high only in IDLE, so a request offered mid-message simply waits.
   localparam logic [1:0] OP_STATUS = 2'b00;
   localparam logic [1:0] OP_READ   = 2'b01;
   localparam logic [1:0] OP_WRITE  = 2'b10;
   localparam logic [1:0] OP_RSVD   = 2'b11;

   localparam int CW = $clog2(TIMEOUT + SS_SETUP + BYTE_GAP + 1);
   localparam logic [CW-1:0] SETUP_LAST = CW'(SS_SETUP - 1);
   localparam logic [CW-1:0] GAP_LAST   = CW'((BYTE_GAP > 0) ? BYTE_GAP - 1 : 0);
   // WAIT_LAST places the DONE cycle exactly TIMEOUT cycles after byteStart.
   localparam logic [CW-1:0] WAIT_LAST  = CW'(TIMEOUT - 2);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_SEND, S_WAIT, S_GAP, S_DONE
   } state_t;

   state_t        state, state_nx;
   logic [1:0]    op_q, op_nx;
   logic [3:0]    id_q, id_nx;
   logic [31:0]   wd_q, wd_nx;
   logic [2:0]    idx_q, idx_nx;
   logic [CW-1:0] cnt_q, cnt_nx;
   logic [31:0]   acc_q, acc_nx;
   logic [31:0]   data_nx;
   logic          err_nx;
   logic          ss_nx;
   logic          rsp_load;
   logic          last_byte;

   function automatic logic [7:0] frame_byte(input logic [1:0] op, input logic [3:0] id,
                                             input logic [31:0] wd, input logic [2:0] idx);
      logic [7:0] b;
      b = 8'h00;
      case (idx)
         3'd0: begin
            if (op == OP_READ)       b = {4'b1000, id};
            else if (op == OP_WRITE) b = {4'b1100, id};
         end
         3'd1: if (op == OP_WRITE) b = wd[31:24];
         3'd2: if (op == OP_WRITE) b = wd[23:16];
         3'd3: if (op == OP_WRITE) b = wd[15:8];
         3'd4: if (op == OP_WRITE) b = wd[7:0];
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   always_ff @(posedge sysClk or posedge usrReset) begin
      if (usrReset) begin
         state   <= S_IDLE;
         op_q    <= '0;
         id_q    <= '0;
         wd_q    <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         acc_q   <= '0;
         rspData <= '0;
         rspErr  <= 1'b0;
         ssN     <= 1'b1;
      end else begin
         state <= state_nx;
         op_q  <= op_nx;
         id_q  <= id_nx;
         wd_q  <= wd_nx;
         idx_q <= idx_nx;
         cnt_q <= cnt_nx;
         acc_q <= acc_nx;
         ssN   <= ss_nx;
         if (rsp_load) begin
            rspData <= data_nx;
            rspErr  <= err_nx;
         end
      end
   end

   always_comb begin
      state_nx  = state;
      op_nx     = op_q;
      id_nx     = id_q;
      wd_nx     = wd_q;
      idx_nx    = idx_q;
      cnt_nx    = cnt_q;
      acc_nx    = acc_q;
      err_nx    = 1'b0;
      rsp_load  = 1'b0;
      byteStart = 1'b0;
      last_byte = (op_q == OP_STATUS) ? (idx_q == 3'd1) : (idx_q == 3'd4);
      case (state)
         S_IDLE: begin
            if (reqValid) begin
               op_nx  = reqOp;
               id_nx  = reqRegId;
               wd_nx  = reqWrData;
               idx_nx = '0;
               cnt_nx = '0;
               acc_nx = '0;
               if (reqOp == OP_RSVD) begin
                  state_nx = S_DONE;
                  rsp_load = 1'b1;
                  err_nx   = 1'b1;
               end else begin
                  state_nx = S_SETUP;
               end
            end
         end
         S_SETUP: begin
            if (cnt_q == SETUP_LAST) begin
               state_nx = S_SEND;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt_q + 1'b1;
            end
         end
         S_SEND: begin
            if (!byteBusy) begin
               byteStart = 1'b1;
               cnt_nx    = '0;
               state_nx  = S_WAIT;
            end
         end
         S_WAIT: begin
            if (byteRxValid) begin
               // Status keeps only byte 1; read shifts bytes 1..4 in MSB first.
               if (op_q == OP_STATUS && idx_q == 3'd1) acc_nx = {24'h0, byteRx};
               else if (op_q == OP_READ && idx_q != 3'd0) acc_nx = {acc_q[23:0], byteRx};
               if (last_byte) begin
                  state_nx = S_DONE;
                  rsp_load = 1'b1;
               end else begin
                  idx_nx   = idx_q + 3'd1;
                  cnt_nx   = '0;
                  state_nx = (BYTE_GAP == 0) ? S_SEND : S_GAP;
               end
            end else if (cnt_q == WAIT_LAST) begin
               state_nx = S_DONE;
               rsp_load = 1'b1;
               err_nx   = 1'b1;
            end else begin
               cnt_nx = cnt_q + 1'b1;
            end
         end
         S_GAP: begin
            if (cnt_q == GAP_LAST) begin
               state_nx = S_SEND;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt_q + 1'b1;
            end
         end
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
      data_nx = (err_nx || op_q == OP_WRITE) ? 32'h0 : acc_nx;
      ss_nx   = !(state_nx inside {S_SETUP, S_SEND, S_WAIT, S_GAP});
   end

   assign reqReady = (state == S_IDLE);
   assign rspValid = (state == S_DONE);
   assign byteTx   = frame_byte(op_q, id_q, wd_q, idx_q);

endmodule

// File: tb/tb_spi_msg_master.sv
// Bench for spi_msg_master: byte-shifter/slave model, table of directed messages,
// timeout and mid-message reset sequences, then randomized messages against a model.
module tb_spi_msg_master;

   localparam int SS_SETUP = 2;
   localparam int BYTE_GAP = 1;
   localparam int TIMEOUT  = 15;

   logic        sysClk = 1'b0;
   logic        usrReset;
   logic        reqValid;
   logic        reqReady;
   logic [1:0]  reqOp;
   logic [3:0]  reqRegId;
   logic [31:0] reqWrData;
   logic        rspValid;
   logic [31:0] rspData;
   logic        rspErr;
   logic        ssN;
   logic        byteStart;
   logic [7:0]  byteTx;
   logic        byteBusy;
   logic        byteRxValid;
   logic [7:0]  byteRx;

   spi_msg_master #(.SS_SETUP(SS_SETUP), .BYTE_GAP(BYTE_GAP), .TIMEOUT(TIMEOUT)) dut (
      .sysClk(sysClk), .usrReset(usrReset),
      .reqValid(reqValid), .reqReady(reqReady), .reqOp(reqOp), .reqRegId(reqRegId),
      .reqWrData(reqWrData), .rspValid(rspValid), .rspData(rspData), .rspErr(rspErr),
      .ssN(ssN), .byteStart(byteStart), .byteTx(byteTx), .byteBusy(byteBusy),
      .byteRxValid(byteRxValid), .byteRx(byteRx)
   );

   // ---------------- clock ----------------
   always #5 sysClk = ~sysClk;

   typedef struct {
      logic [1:0]  op;
      logic [3:0]  id;
      logic [31:0] wd;
      logic [39:0] rx;     // slave reply, byte 0 in [39:32]
      int          delay;  // byteStart -> byteRxValid cycles
      int          tail;   // busy cycles lingering after byteRxValid
      logic [39:0] tx;     // expected MOSI bytes, byte 0 in [39:32]
      int          n;      // expected number of bytes
      logic [31:0] data;
      logic        err;
      int          lat;    // accept cycle = 1, cycle of rspValid; -1 = unchecked
   } vec_t;

   int n_total = 0;
   int n_pass  = 0;

   int s_delay = 8;
   int s_tail  = 0;
   bit s_mute  = 1'b0;
   int stab_bad = 0;
   logic [7:0] rx_q[$];
   logic [7:0] tx_log[$];
   logic [7:0] exp_q[$];

   task automatic chk(input string name, input string what, input logic [31:0] got,
                      input logic [31:0] exp);
      n_total++;
      if (got !== exp) $display("FAIL %s/%s got=%0h exp=%0h", name, what, got, exp);
      else n_pass++;
   endtask

   function automatic vec_t mk(input logic [1:0] op, input logic [3:0] id, input logic [31:0] wd,
                               input logic [39:0] rx, input int delay, input int tail,
                               input logic [39:0] tx, input int n, input logic [31:0] data,
                               input logic err, input int lat);
      vec_t v;
      v.op = op; v.id = id; v.wd = wd; v.rx = rx; v.delay = delay; v.tail = tail;
      v.tx = tx; v.n = n; v.data = data; v.err = err; v.lat = lat;
      return v;
   endfunction

   // Reference model: what the protocol says each request should produce.
   function automatic vec_t model(input logic [1:0] op, input logic [3:0] id,
                                  input logic [31:0] wd, input logic [39:0] rx,
                                  input int delay, input int tail);
      vec_t v;
      v = mk(op, id, wd, rx, delay, tail, 40'h0, 0, 32'h0, 1'b0, -1);
      case (op)
         2'b00: begin v.n = 2; v.tx = 40'h0;              v.data = {24'h0, rx[31:24]}; end
         2'b01: begin v.n = 5; v.tx = {4'b1000, id, 32'h0}; v.data = rx[31:0]; end
         2'b10: begin v.n = 5; v.tx = {4'b1100, id, wd};  v.data = 32'h0; end
         default: begin v.n = 0; v.err = 1'b1; end
      endcase
      if (op == 2'b11) v.lat = 2;
      else if (tail == 0)
         v.lat = 1 + SS_SETUP + v.n * (1 + delay) + (v.n - 1) * BYTE_GAP + 1;
      return v;
   endfunction

   // ---------------- byte shifter / slave model ----------------
   initial begin
      bit         pend;
      int         cnt;
      int         tail;
      logic [7:0] held_tx;
      pend = 1'b0; cnt = 0; tail = 0; held_tx = 8'h0;
      byteBusy = 1'b0; byteRxValid = 1'b0; byteRx = 8'h0;
      forever begin
         @(negedge sysClk);
         byteRxValid = 1'b0;
         if (usrReset) begin
            pend = 1'b0; tail = 0; byteBusy = 1'b0;
         end else if (pend) begin
            cnt--;
            if (cnt == 0) begin
               byteRxValid = 1'b1;
               if (rx_q.size() > 0) byteRx = rx_q.pop_front();
               else byteRx = 8'($urandom);
               pend = 1'b0;
               tail = s_tail;
               byteBusy = (tail > 0);
            end else begin
               byteBusy = 1'b1;
            end
         end else if (tail > 0) begin
            tail--;
            byteBusy = (tail > 0);
         end
         #1;
         if (pend && byteTx !== held_tx) stab_bad++;
         if (byteStart && !pend && !usrReset) begin
            tx_log.push_back(byteTx);
            held_tx = byteTx;
            if (!s_mute) begin
               pend = 1'b1;
               cnt  = s_delay;
            end
         end
      end
   end

   // ---------------- driver + per-message checks ----------------
   task automatic run_msg(input vec_t v, input bit mute, input string name);
      int guard, cyc, lat, pulses, ss_low, ss_bad, rdy_bad, first_start;
      logic [31:0] got_data;
      logic got_err, got_ss;
      s_delay = v.delay; s_tail = v.tail; s_mute = mute;
      rx_q.delete();
      exp_q.delete();
      for (int i = 0; i < v.n; i++) begin
         rx_q.push_back(v.rx[39 - 8*i -: 8]);
         exp_q.push_back(v.tx[39 - 8*i -: 8]);
      end
      tx_log.delete();
      stab_bad = 0;
      @(negedge sysClk); #3;
      reqValid = 1'b1; reqOp = v.op; reqRegId = v.id; reqWrData = v.wd;
      guard = 0;
      while (!reqReady && guard < 100) begin
         @(negedge sysClk); #3;
         guard++;
      end
      chk(name, "accept", 32'(guard < 100), 32'd1);
      @(posedge sysClk); #1;
      reqValid = 1'b0; reqOp = 2'($urandom); reqRegId = 4'($urandom); reqWrData = $urandom;
      cyc = 1; lat = 0; pulses = 0; ss_low = 0; ss_bad = 0; rdy_bad = 0; first_start = 0;
      got_data = '0; got_err = 1'b0; got_ss = 1'b0;
      while (cyc < 400 && (pulses == 0 || cyc < lat + 3)) begin
         @(negedge sysClk); #2;
         cyc++;
         if (!ssN) ss_low++;
         if (byteStart && ssN) ss_bad++;
         if (byteStart && first_start == 0) first_start = cyc;
         if (rspValid) begin
            pulses++;
            if (pulses == 1) begin
               lat = cyc; got_data = rspData; got_err = rspErr; got_ss = ssN;
            end
         end else if (pulses == 0 && reqReady) begin
            rdy_bad++;
         end
      end
      chk(name, "rsp_pulses", 32'(pulses), 32'd1);
      chk(name, "rsp_data", got_data, v.data);
      chk(name, "rsp_err", 32'(got_err), 32'(v.err));
      chk(name, "ssn_at_rsp", 32'(got_ss), 32'd1);
      chk(name, "start_outside_ss", 32'(ss_bad), 32'd0);
      chk(name, "ready_held_off", 32'(rdy_bad), 32'd0);
      chk(name, "tx_count", 32'(tx_log.size()), 32'(v.n));
      for (int i = 0; i < v.n; i++)
         if (i < tx_log.size()) chk(name, $sformatf("tx_byte%0d", i), 32'(tx_log[i]), 32'(exp_q[i]));
      chk(name, "tx_stable", 32'(stab_bad), 32'd0);
      if (v.lat > 0) begin
         chk(name, "latency", 32'(lat), 32'(v.lat));
         // ssN low from the cycle after accept up to the cycle before rspValid
         chk(name, "ss_low_cycles", 32'(ss_low), 32'(v.lat - 2));
      end
      if (mute) chk(name, "timeout_latency", 32'(lat), 32'(first_start + TIMEOUT));
      chk(name, "idle_ready", 32'(reqReady), 32'd1);
      chk(name, "rsp_data_held", rspData, v.data);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      vec_t tbl[7];
      vec_t v;
      int guard, seen;
      logic [1:0] op;

      tbl[0] = mk(2'b00, 4'h0, 32'h0,         40'h11_5A_00_00_00, 8, 0, 40'h00_00_00_00_00, 2, 32'h0000005A, 1'b0, 23);
      tbl[1] = mk(2'b01, 4'h3, 32'h0,         40'h00_DE_AD_BE_EF, 8, 0, 40'h83_00_00_00_00, 5, 32'hDEADBEEF, 1'b0, 53);
      tbl[2] = mk(2'b10, 4'h1, 32'h12345678,  40'hFF_FF_FF_FF_FF, 8, 0, 40'hC1_12_34_56_78, 5, 32'h0,        1'b0, 53);
      tbl[3] = mk(2'b11, 4'h5, 32'hAAAA5555,  40'h0,              8, 0, 40'h0,              0, 32'h0,        1'b1, 2);
      tbl[4] = mk(2'b01, 4'hF, 32'h0,         40'h00_01_02_03_04, 3, 0, 40'h8F_00_00_00_00, 5, 32'h01020304, 1'b0, 28);
      tbl[5] = mk(2'b00, 4'h7, 32'h0,         40'h00_C3_00_00_00, 5, 2, 40'h00_00_00_00_00, 2, 32'h000000C3, 1'b0, -1);
      tbl[6] = mk(2'b10, 4'h0, 32'hFFFFFFFF,  40'h0,              1, 0, 40'hC0_FF_FF_FF_FF, 5, 32'h0,        1'b0, 18);

      usrReset = 1'b1; reqValid = 1'b0; reqOp = 2'b00; reqRegId = 4'h0; reqWrData = 32'h0;
      #3;
      chk("reset", "reqReady", 32'(reqReady), 32'd1);
      chk("reset", "ssN", 32'(ssN), 32'd1);
      chk("reset", "byteStart", 32'(byteStart), 32'd0);
      chk("reset", "byteTx", 32'(byteTx), 32'd0);
      chk("reset", "rspValid", 32'(rspValid), 32'd0);
      chk("reset", "rspData", rspData, 32'd0);
      chk("reset", "rspErr", 32'(rspErr), 32'd0);
      @(negedge sysClk);
      @(negedge sysClk); #3;
      usrReset = 1'b0;

      for (int i = 0; i < 7; i++) run_msg(tbl[i], 1'b0, $sformatf("tbl%0d", i));

      // slave never answers: status aborts with error
      run_msg(mk(2'b00, 4'h0, 32'h0, 40'h0, 8, 0, 40'h0, 1, 32'h0, 1'b1, -1), 1'b1, "timeout");

      // reset while the second byte of a read is in flight
      s_delay = 8; s_tail = 0; s_mute = 1'b0;
      rx_q.delete(); tx_log.delete();
      repeat (5) rx_q.push_back(8'h77);
      @(negedge sysClk); #3;
      reqValid = 1'b1; reqOp = 2'b01; reqRegId = 4'h2; reqWrData = 32'h0;
      guard = 0;
      while (!reqReady && guard < 100) begin
         @(negedge sysClk); #3;
         guard++;
      end
      @(posedge sysClk); #1;
      reqValid = 1'b0;
      guard = 0;
      while (tx_log.size() < 2 && guard < 200) begin
         @(negedge sysClk); #2;
         guard++;
      end
      chk("midreset", "reach_byte2", 32'(guard < 200), 32'd1);
      @(negedge sysClk); #2;
      chk("midreset", "ssN_low_before", 32'(ssN), 32'd0);
      usrReset = 1'b1;
      #1;
      chk("midreset", "ssN_async", 32'(ssN), 32'd1);
      chk("midreset", "byteStart", 32'(byteStart), 32'd0);
      chk("midreset", "rspValid", 32'(rspValid), 32'd0);
      @(negedge sysClk);
      @(negedge sysClk); #3;
      usrReset = 1'b0;
      seen = 0;
      repeat (30) begin
         @(negedge sysClk); #2;
         if (rspValid || !ssN) seen++;
      end
      chk("midreset", "quiet_after", 32'(seen), 32'd0);
      run_msg(tbl[0], 1'b0, "post_reset");

      // randomized messages against the model
      for (int k = 0; k < 16; k++) begin
         if ($urandom_range(0, 9) == 0) op = 2'b11;
         else op = 2'($urandom_range(0, 2));
         v = model(op, 4'($urandom), $urandom, {32'($urandom), 8'($urandom)},
                   int'($urandom_range(1, 12)), int'($urandom_range(0, 3)));
         run_msg(v, 1'b0, $sformatf("rand%0d", k));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
